// File: rtl/huff_stream_decoder.sv
// rtl/huff_stream_decoder.sv - serial prefix-code decoder with loadable code table
// Optional feature: define HUFF_ERR_CNT_EN to add the saturating err_count output.
module huff_stream_decoder #(
    parameter int SYM_W   = 3,
    parameter int MAX_LEN = 4,
    parameter int LEN_W   = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               bit_in,
    input  logic               bit_valid,
    input  logic               tbl_we,
    input  logic [SYM_W-1:0]   tbl_addr,
    input  logic [LEN_W-1:0]   tbl_len,
    input  logic [MAX_LEN-1:0] tbl_code,
    output logic [SYM_W-1:0]   sym_out,
    output logic               sym_valid,
    output logic               err,
    output logic [15:0]        sym_count
`ifdef HUFF_ERR_CNT_EN
    ,
    output logic [7:0]         err_count
`endif
);

    localparam int NUM_SYM = 1 << SYM_W;

    generate
        if (MAX_LEN < SYM_W) begin : g_bad_max_len
            $error("huff_stream_decoder: MAX_LEN must be >= SYM_W");
        end
        if ((1 << LEN_W) <= MAX_LEN) begin : g_bad_len_w
            $error("huff_stream_decoder: LEN_W too narrow to hold MAX_LEN");
        end
    endgenerate

    logic [LEN_W-1:0]   tbl_len_q  [NUM_SYM];
    logic [MAX_LEN-1:0] tbl_code_q [NUM_SYM];

    logic [MAX_LEN-1:0] acc;
    logic [LEN_W-1:0]   cnt;

    logic [MAX_LEN-1:0] nacc;
    logic [LEN_W-1:0]   ncnt;
    logic [MAX_LEN-1:0] mask;
    logic               hit;
    logic [SYM_W-1:0]   hit_idx;
    logic               full;
    logic               err_set;

    always_comb begin
        ncnt    = cnt + LEN_W'(1);
        nacc    = (acc << 1) | MAX_LEN'(bit_in);
        mask    = '0;
        hit     = 1'b0;
        hit_idx = '0;
        for (int b = 0; b < MAX_LEN; b++) begin
            mask[b] = (b < int'(ncnt));
        end
        // Scan downwards so the lowest matching index is the one left standing.
        for (int i = NUM_SYM - 1; i >= 0; i--) begin
            if ((tbl_len_q[i] == ncnt) && (tbl_len_q[i] != '0) &&
                (((tbl_code_q[i] ^ nacc) & mask) == '0)) begin
                hit     = 1'b1;
                hit_idx = SYM_W'(i);
            end
        end
        full    = (ncnt == LEN_W'(MAX_LEN));
        err_set = bit_valid && !hit && full;
    end

    // Table updates land at the edge, so a same-cycle bit still sees the old entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_SYM; i++) begin
                tbl_len_q[i]  <= LEN_W'(SYM_W);
                tbl_code_q[i] <= MAX_LEN'(i);
            end
        end else if (tbl_we) begin
            tbl_len_q[tbl_addr]  <= tbl_len;
            tbl_code_q[tbl_addr] <= tbl_code;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc       <= '0;
            cnt       <= '0;
            sym_out   <= '0;
            sym_valid <= 1'b0;
            err       <= 1'b0;
            sym_count <= '0;
        end else begin
            sym_valid <= 1'b0;
            err       <= 1'b0;
            if (bit_valid) begin
                if (hit) begin
                    sym_out   <= hit_idx;
                    sym_valid <= 1'b1;
                    acc       <= '0;
                    cnt       <= '0;
                    if (sym_count != 16'hFFFF) begin
                        sym_count <= sym_count + 16'd1;
                    end
                end else if (full) begin
                    err <= 1'b1;
                    acc <= '0;
                    cnt <= '0;
                end else begin
                    acc <= nacc;
                    cnt <= ncnt;
                end
            end
        end
    end

`ifdef HUFF_ERR_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_count <= '0;
        end else if (err_set && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_huff_stream_decoder.sv
// tb/tb_huff_stream_decoder.sv - directed self-checking bench for huff_stream_decoder
module tb_huff_stream_decoder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        bit_in = 1'b0;
    logic        bit_valid = 1'b0;
    logic        tbl_we = 1'b0;
    logic [2:0]  tbl_addr = '0;
    logic [2:0]  tbl_len = '0;
    logic [3:0]  tbl_code = '0;
    logic [2:0]  sym_out;
    logic        sym_valid;
    logic        err;
    logic [15:0] sym_count;
`ifdef HUFF_ERR_CNT_EN
    logic [7:0]  err_count;
`endif

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    huff_stream_decoder #(.SYM_W(3), .MAX_LEN(4), .LEN_W(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .tbl_we    (tbl_we),
        .tbl_addr  (tbl_addr),
        .tbl_len   (tbl_len),
        .tbl_code  (tbl_code),
        .sym_out   (sym_out),
        .sym_valid (sym_valid),
        .err       (err),
        .sym_count (sym_count)
`ifdef HUFF_ERR_CNT_EN
        ,
        .err_count (err_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle with optional bit; outputs sampled at the following negedge.
    task automatic step(input string tag, input logic v, input logic b,
                        input logic exp_valid, input logic exp_err, input logic [2:0] exp_sym);
        bit_in    = b;
        bit_valid = v;
        @(negedge clk);
        bit_valid = 1'b0;
        chk({tag, ".sym_valid"}, 16'(sym_valid), 16'(exp_valid));
        chk({tag, ".err"},       16'(err),       16'(exp_err));
        chk({tag, ".sym_out"},   16'(sym_out),   16'(exp_sym));
    endtask

    task automatic wr(input logic [2:0] a, input logic [2:0] l, input logic [3:0] c);
        tbl_we   = 1'b1;
        tbl_addr = a;
        tbl_len  = l;
        tbl_code = c;
        @(negedge clk);
        tbl_we   = 1'b0;
    endtask

    initial begin
        // Asynchronous reset with no clock edge in between
        #1 reset = 1'b1;
        #2;
        chk("rst.sym_out",   16'(sym_out),   16'd0);
        chk("rst.sym_valid", 16'(sym_valid), 16'd0);
        chk("rst.err",       16'(err),       16'd0);
        chk("rst.sym_count", sym_count,      16'd0);
`ifdef HUFF_ERR_CNT_EN
        chk("rst.err_count", 16'(err_count), 16'd0);
`endif
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Default fixed-length table: 1,0,1 -> 5
        step("d101.b0", 1, 1, 0, 0, 3'd0);
        step("d101.b1", 1, 0, 0, 0, 3'd0);
        step("d101.b2", 1, 1, 1, 0, 3'd5);
        chk("d101.count", sym_count, 16'd1);
        step("d101.idle", 0, 0, 0, 0, 3'd5);

        // Gapped bits 1,_,_,_,1,_,_,_,0 -> 6, single pulse
        step("gap.b0", 1, 1, 0, 0, 3'd5);
        for (int i = 0; i < 3; i++) step("gap.i0", 0, 1, 0, 0, 3'd5);
        step("gap.b1", 1, 1, 0, 0, 3'd5);
        for (int i = 0; i < 3; i++) step("gap.i1", 0, 0, 0, 0, 3'd5);
        step("gap.b2", 1, 0, 1, 0, 3'd6);
        step("gap.idle", 0, 0, 0, 0, 3'd6);
        chk("gap.count", sym_count, 16'd2);

        // Reset mid-code discards 1,1; then 0,1,0 -> 2
        step("rmid.b0", 1, 1, 0, 0, 3'd6);
        step("rmid.b1", 1, 1, 0, 0, 3'd6);
        #1 reset = 1'b1;
        #1;
        chk("rmid.sym_out", 16'(sym_out), 16'd0);
        chk("rmid.count",   sym_count,    16'd0);
        @(negedge clk);
        reset = 1'b0;
        step("rmid.c0", 1, 0, 0, 0, 3'd0);
        step("rmid.c1", 1, 1, 0, 0, 3'd0);
        step("rmid.c2", 1, 0, 1, 0, 3'd2);
        chk("rmid.count2", sym_count, 16'd1);

        // Variable-length table: 0 / 10 / 110 / 1110
        wr(3'd0, 3'd1, 4'b0000);
        wr(3'd1, 3'd2, 4'b0010);
        wr(3'd2, 3'd3, 4'b0110);
        wr(3'd3, 3'd4, 4'b1110);
        for (int i = 4; i < 8; i++) wr(3'(i), 3'd0, 4'd0);
        step("vl.b0", 1, 0, 1, 0, 3'd0);
        step("vl.b1", 1, 1, 0, 0, 3'd0);
        step("vl.b2", 1, 0, 1, 0, 3'd1);
        step("vl.b3", 1, 1, 0, 0, 3'd1);
        step("vl.b4", 1, 1, 0, 0, 3'd1);
        step("vl.b5", 1, 0, 1, 0, 3'd2);
        chk("vl.count", sym_count, 16'd4);

        // Invalid 1111 -> err, sym_out held; then 0 -> 0
        step("inv.b0", 1, 1, 0, 0, 3'd2);
        step("inv.b1", 1, 1, 0, 0, 3'd2);
        step("inv.b2", 1, 1, 0, 0, 3'd2);
        step("inv.b3", 1, 1, 0, 1, 3'd2);
        step("inv.b4", 1, 0, 1, 0, 3'd0);
        chk("inv.count", sym_count, 16'd5);
`ifdef HUFF_ERR_CNT_EN
        chk("inv.err_count", 16'(err_count), 16'd1);
`endif

        // Same-cycle write of entry4 (len1 code 1) with bit 1: old table used
        tbl_we   = 1'b1;
        tbl_addr = 3'd4;
        tbl_len  = 3'd1;
        tbl_code = 4'b0001;
        step("wsc.b0", 1, 1, 0, 0, 3'd0);
        tbl_we   = 1'b0;
        step("wsc.b1", 1, 0, 1, 0, 3'd1);
        step("wsc.b2", 1, 1, 1, 0, 3'd4);
        chk("wsc.count", sym_count, 16'd7);

        // Entries 2 and 5 both len2 code 01: lowest index wins
        for (int i = 0; i < 8; i++) wr(3'(i), 3'd0, 4'd0);
        wr(3'd2, 3'd2, 4'b0001);
        wr(3'd5, 3'd2, 4'b0001);
        step("pri.b0", 1, 0, 0, 0, 3'd4);
        step("pri.b1", 1, 1, 1, 0, 3'd2);
        step("pri.idle", 0, 0, 0, 0, 3'd2);
        chk("pri.count", sym_count, 16'd8);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
